// File: rtl/count_uart_pkg.sv
// Shared encodings and frame constants for the count UART transmitter.
package count_uart_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  localparam int FRAME_BITS_8N1 = 10;
  localparam int FRAME_BITS_PAR = 11;

endpackage

// File: rtl/count_uart_baud_tick.sv
// Bit-period timer: tick is high in the last cycle of each serial bit.
module count_uart_baud_tick #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  output logic tick
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] PRE  = CW'(CLKS_PER_BIT - 2);

  logic [CW-1:0] cnt;

  // tick is registered one count early so it lines up with cnt == LAST
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt  <= '0;
      tick <= 1'b0;
    end else if (clear) begin
      cnt  <= '0;
      tick <= 1'b0;
    end else begin
      cnt  <= (cnt == LAST) ? '0 : cnt + 1'b1;
      tick <= (cnt == PRE);
    end
  end

endmodule

// File: rtl/count_uart_tx.sv
// Serial transmitter for the running count: 8N1 frames, or 8E1 when
// COUNT_UART_TX_PARITY_EN is defined.
module count_uart_tx
  import count_uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16,
  parameter int DATA_W       = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ena,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              tx_ready,
  output logic              tx_serial,
  output logic              tx_busy,
  output logic              frame_done
);

  localparam int IW = $clog2(DATA_W);

  state_t            state;
  logic [DATA_W-1:0] shift;
  logic [IW-1:0]     bit_idx;
  logic              ready_q;
  logic              tick;
  logic              accept;

  // ready_q keeps tx_ready low through reset and the first edge after release
  assign tx_ready   = ready_q && ena;
  assign accept     = tx_valid && tx_ready;
  assign frame_done = (state == STOP) && tick;

  count_uart_baud_tick #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_baud (
    .clk  (clk),
    .rst_n(rst_n),
    .clear(accept),
    .tick (tick)
  );

`ifdef COUNT_UART_TX_PARITY_EN
  logic parity_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      parity_q <= 1'b0;
    else if (accept) parity_q <= ^tx_data;
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      shift     <= '0;
      bit_idx   <= '0;
      tx_serial <= 1'b1;
      tx_busy   <= 1'b0;
      ready_q   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          ready_q <= 1'b1;
          if (accept) begin
            state     <= START;
            shift     <= tx_data;
            bit_idx   <= '0;
            tx_serial <= 1'b0;
            tx_busy   <= 1'b1;
            ready_q   <= 1'b0;
          end
        end
        START: if (tick) begin
          state     <= DATA;
          tx_serial <= shift[0];
        end
        DATA: if (tick) begin
          if (bit_idx == IW'(DATA_W - 1)) begin
`ifdef COUNT_UART_TX_PARITY_EN
            state     <= PARITY;
            tx_serial <= parity_q;
`else
            state     <= STOP;
            tx_serial <= 1'b1;
`endif
          end else begin
            bit_idx   <= bit_idx + 1'b1;
            shift     <= shift >> 1;
            tx_serial <= shift[1];
          end
        end
        PARITY: if (tick) begin
          state     <= STOP;
          tx_serial <= 1'b1;
        end
        STOP: if (tick) begin
          state   <= IDLE;
          tx_busy <= 1'b0;
          ready_q <= 1'b1;
        end
        default: begin
          state     <= IDLE;
          tx_serial <= 1'b1;
          tx_busy   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_count_uart_tx.sv
// Directed bench for count_uart_tx at CLKS_PER_BIT=4; honours COUNT_UART_TX_PARITY_EN.
module tb_count_uart_tx;

  localparam int C = 4;
`ifdef COUNT_UART_TX_PARITY_EN
  localparam int NB = 11;
`else
  localparam int NB = 10;
`endif

  logic       clk = 1'b0;
  logic       rst_n;
  logic       ena;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic       tx_serial;
  logic       tx_busy;
  logic       frame_done;

  int n_chk = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  count_uart_tx #(.CLKS_PER_BIT(C), .DATA_W(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .ena       (ena),
    .tx_data   (tx_data),
    .tx_valid  (tx_valid),
    .tx_ready  (tx_ready),
    .tx_serial (tx_serial),
    .tx_busy   (tx_busy),
    .frame_done(frame_done)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Offer d, find the start bit, sample each slot mid-bit and watch frame_done.
  // Returns at the negedge of the first IDLE cycle after the frame.
  task automatic send(input logic [7:0] d, input logic [7:0] nxt, input bit hold,
                      input bit drop_ena, input logic exp_rdy, input string tag,
                      output int wait_n, output logic [10:0] got);
    logic [10:0] exp;
    int fd_cnt, fd_pos;
    bit found;
    got = '1; exp = '1; fd_cnt = 0; fd_pos = -1; found = 0; wait_n = 0;
    tx_data = d;
    tx_valid = 1'b1;
    while (!found && wait_n < 100) begin
      @(negedge clk);
      wait_n++;
      if (tx_serial === 1'b0) found = 1;
    end
    if (!found) begin
      check({tag, "_start"}, 32'd0, 32'd1);
      tx_valid = 1'b0;
      return;
    end
    if (!hold) tx_valid = 1'b0;
    for (int c = 0; c < NB*C; c++) begin
      if (hold && c == 5) tx_data = nxt;
      if (drop_ena && c == 10) ena = 1'b0;
      if (c % C == C/2) got[c/C] = tx_serial;
      if (frame_done) begin fd_cnt++; fd_pos = c; end
      @(negedge clk);
    end
    exp[0] = 1'b0;
    for (int i = 0; i < 8; i++) exp[1+i] = d[i];
`ifdef COUNT_UART_TX_PARITY_EN
    exp[9] = ^d;
`endif
    exp[NB-1] = 1'b1;
    check({tag, "_bits"}, 32'(got), 32'(exp));
    check({tag, "_done_cnt"}, fd_cnt, 1);
    check({tag, "_done_pos"}, fd_pos, NB*C-1);
    check({tag, "_rdy_after"}, 32'(tx_ready), 32'(exp_rdy));
  endtask

  initial begin
    int w, bad_cyc;
    logic [10:0] bits;
    rst_n = 1'b0; ena = 1'b1; tx_valid = 1'b0; tx_data = 8'h00;

    // reset state
    repeat (3) @(negedge clk);
    check("rst_serial", 32'(tx_serial), 1);
    check("rst_ready", 32'(tx_ready), 0);
    check("rst_busy", 32'(tx_busy), 0);
    check("rst_done", 32'(frame_done), 0);

    // release and idle for 50 cycles
    #2 rst_n = 1'b1;
    @(negedge clk);
    check("rel_ready", 32'(tx_ready), 1);
    check("rel_serial", 32'(tx_serial), 1);
    bad_cyc = 0;
    repeat (50) begin
      @(negedge clk);
      if (tx_serial !== 1'b1 || tx_busy !== 1'b0 || tx_ready !== 1'b1) bad_cyc++;
    end
    check("idle50", bad_cyc, 0);

    // tx_valid raised in the release cycle must wait one more edge
    #2 rst_n = 1'b0;
    @(negedge clk);
    tx_valid = 1'b1; tx_data = 8'h5A;
    #2 rst_n = 1'b1;
    @(negedge clk);
    check("relv_noacc", 32'(tx_serial), 1);
    @(negedge clk);
    check("relv_acc", 32'(tx_serial), 0);
    tx_valid = 1'b0;
    repeat (NB*C + 4) @(negedge clk);
    check("relv_idle", 32'(tx_busy), 0);

    // single frame 0xA5
    send(8'hA5, 8'hA5, 0, 0, 1'b1, "a5", w, bits);
    check("a5_lat", w, 1);
    check("a5_data", 32'(bits[8:1]), 32'h0A5);

    // back-to-back with data change during the first frame
    send(8'h00, 8'hFF, 1, 0, 1'b1, "b2b0", w, bits);
    check("b2b_idle", 32'(tx_serial), 1);
    send(8'hFF, 8'hFF, 0, 0, 1'b1, "b2b1", w, bits);
    check("b2b_gap", w, 1);

    // reset during data bit 3 of 0x3C
    tx_data = 8'h3C; tx_valid = 1'b1;
    w = 0;
    while (tx_serial !== 1'b0 && w < 100) begin @(negedge clk); w++; end
    tx_valid = 1'b0;
    repeat (4*C + 2) @(negedge clk);
    check("mid_busy", 32'(tx_busy), 1);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_serial", 32'(tx_serial), 1);
    check("mid_rst_busy", 32'(tx_busy), 0);
    @(negedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    send(8'h3C, 8'h3C, 0, 0, 1'b1, "post_rst", w, bits);

    // ena low in IDLE blocks accepts
    ena = 1'b0; tx_valid = 1'b1; tx_data = 8'h11;
    @(negedge clk);
    check("ena0_ready", 32'(tx_ready), 0);
    bad_cyc = 0;
    repeat (30) begin
      @(negedge clk);
      if (tx_serial !== 1'b1 || tx_busy !== 1'b0) bad_cyc++;
    end
    check("ena0_quiet", bad_cyc, 0);
    tx_valid = 1'b0; ena = 1'b1;
    @(negedge clk);

    // ena dropped mid-frame: frame still completes
    send(8'h96, 8'h96, 0, 1, 1'b0, "ena_drop", w, bits);
    ena = 1'b1;
    @(negedge clk);

`ifdef COUNT_UART_TX_PARITY_EN
    send(8'h07, 8'h07, 0, 0, 1'b1, "par07", w, bits);
    check("par07_bit", 32'(bits[9]), 1);
    send(8'h03, 8'h03, 0, 0, 1'b1, "par03", w, bits);
    check("par03_bit", 32'(bits[9]), 0);
`endif

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/count_uart_tx.md
Name: count_uart_tx

Overview:
Serial transmitter for the 8-bit running count produced by the counter block inside tt_um_mrmola.
- Accepts one byte per valid/ready handshake.
- Shifts the byte out on a single pin as an 8N1 UART frame: start bit, 8 data bits LSB first, stop bit.
- Drives one uo_out bit so that an off-chip receiver can read the count.

Parameters:
- CLKS_PER_BIT, 16, clock cycles per serial bit; legal range is 2 to 4096.
- DATA_W, 8, payload width in bits; fixed at 8 for the top level.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- ena  input  1  design-select enable from the top level.
- tx_data  input  DATA_W  byte to send, typically the counter's currentCount.
- tx_valid  input  1  source has a byte available.
- tx_ready  output  1  transmitter can accept a byte this cycle.
- tx_serial  output  1  serial line; idles high.
- tx_busy  output  1  high while a frame is in progress.
- frame_done  output  1  one-cycle pulse at the end of each frame.

Behaviour:
- Reset values (rst_n low, applied asynchronously):
  - tx_serial=1, tx_ready=0, tx_busy=0, frame_done=0.
  - state=IDLE, baud counter=0, bit index=0, shift register=0.
- tx_ready equals (state==IDLE) && ena. It is registered state decode and has no combinational dependence on tx_valid.
- Accept: a byte is accepted on a rising edge where tx_valid && tx_ready. On that edge tx_data is latched into the shift register and the FSM moves to START.
- Latency: tx_serial goes 0 on the first cycle after the accept edge.
- FSM states and transitions:
  - IDLE: tx_serial=1. Go to START on accept.
  - START: tx_serial=0 for CLKS_PER_BIT cycles, then go to DATA.
  - DATA: tx_serial=shift[0] for CLKS_PER_BIT cycles per bit. Shift right at each bit boundary. After bit index DATA_W-1, go to STOP (or PARITY when enabled).
  - STOP: tx_serial=1 for CLKS_PER_BIT cycles. frame_done=1 in the last STOP cycle. Then go to IDLE.
- Frame length: 10*CLKS_PER_BIT cycles from the first start-bit cycle to the first IDLE cycle.
- Back-to-back frames: tx_ready is high on the first IDLE cycle. If tx_valid is held, the next start bit begins one cycle later, so there is exactly one idle-high cycle between frames.
- tx_busy is high in every state except IDLE.
- Baud counter: width $clog2(CLKS_PER_BIT). Counts 0 to CLKS_PER_BIT-1, wraps at each bit boundary, and is cleared on accept.
- tx_data and tx_valid changes during a frame are ignored. There is no re-latch until the next IDLE.
- ena deasserted in IDLE: no accept occurs, and tx_serial stays 1.
- ena deasserted mid-frame: the frame completes normally.
- rst_n asserted mid-frame: tx_serial goes to 1 immediately, with no glitch to 0. The partial frame is abandoned.
- A tx_valid asserted in the same cycle as rst_n deasserts is not accepted. The first possible accept is on the following edge.

Optional Feature:
- Macro: COUNT_UART_TX_PARITY_EN.
- When defined:
  - A PARITY state is inserted between DATA and STOP.
  - tx_serial in PARITY is the XOR of the 8 latched data bits (even parity), held for CLKS_PER_BIT cycles.
  - Frame length becomes 11*CLKS_PER_BIT.
- When undefined: the PARITY state, its logic and the parity register are absent, and the frame is 8N1 as specified above.

Decomposition:
- Shared package count_uart_pkg holds:
  - the state encoding localparams IDLE=0, START=1, DATA=2, PARITY=3, STOP=4 (3-bit);
  - the frame bit-count constants, 10 and 11.
- One sub-module, count_uart_baud_tick:
  - parameterised by CLKS_PER_BIT;
  - inputs: clk, rst_n, clear;
  - output: a one-cycle tick at each bit boundary.
- The FSM and shift register stay in count_uart_tx.

Test Plan:
1. Reset release with tx_valid=0, ena=1, CLKS_PER_BIT=4 -> tx_serial=1, tx_ready=1 from the first edge after release, tx_busy=0; no change for 50 cycles.
2. Send 0xA5 -> line samples taken at mid-bit are 0, then 1,0,1,0,0,1,0,1, then 1. frame_done pulses exactly once, 40 cycles after the start bit begins, and tx_ready is high on the next cycle.
3. tx_valid held high with data 0x00 then 0xFF -> two complete frames separated by exactly 1 idle-high cycle. tx_data changes during the first frame do not corrupt it.
4. rst_n pulsed low during bit 3 of a 0x3C frame -> tx_serial=1 immediately, tx_busy=0. The next accepted 0x3C frame is fully correct.
5. ena=0 with tx_valid=1 -> tx_ready=0 and no start bit. Dropping ena mid-frame lets the frame finish with frame_done asserted.
6. With COUNT_UART_TX_PARITY_EN defined, send 0x07 -> parity bit is 1 and the frame is 44 cycles. Send 0x03 -> parity bit is 0.
